// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer packet loader slice:
//   - default opcodes CMD_WRITE / CMD_FILL
//   - parser state enumeration
//   - RGB565 pixel type
// No ports (package).
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_FILL  = 8'h02;

  // RGB565: {R[4:0], G[5:0], B[4:0]}
  typedef logic [15:0] pixel_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_PIX_H,
    ST_PIX_L,
    ST_WAIT_ACK,
    ST_CNT_H,
    ST_CNT_L,
    ST_COL_H,
    ST_COL_L,
    ST_FILL_RUN,
    ST_DISCARD
  } state_e;

endpackage

// File: rtl/fb_write_port.sv
// -----------------------------------------------------------------------------
// fb_write_port
// Frame-buffer write handshake. Holds the request, address and data registers
// and advances the address on every accepted write.
//
// Ports:
//   CLK          clock
//   RST          synchronous reset, active-low
//   i_addr_load  load i_addr as the next write address
//   i_addr       start address (already truncated to ADDR_W)
//   i_start      raise the request next cycle with i_data as the pixel
//   i_data       pixel to write
//   i_hold       sampled on an accepted write: keep the request up for another
//                write at the incremented address (back-to-back runs)
//   i_ack        frame buffer accepts the write this cycle
//   o_req        write request
//   o_addr       write word address
//   o_data       write pixel
//   o_done       combinational: a write is accepted this cycle (o_req & i_ack)
// -----------------------------------------------------------------------------
module fb_write_port #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_start,
  input  logic [15:0]       i_data,
  input  logic              i_hold,
  input  logic              i_ack,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_data,
  output logic              o_done
);

  import fb_pkg::*;

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  pixel_t            r_data;
  logic              w_done;

  assign w_done = r_req & i_ack;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      // Address wraps naturally at 2^ADDR_W.
      if (i_addr_load) r_addr <= i_addr;
      else if (w_done) r_addr <= r_addr + ADDR_W'(1);

      if (i_start) begin
        r_req  <= 1'b1;
        r_data <= i_data;
      end else if (w_done) begin
        r_req  <= i_hold;
      end
    end
  end

  assign o_req  = r_req;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_done = w_done;

endmodule

// File: rtl/fb_packet_loader.sv
// -----------------------------------------------------------------------------
// fb_packet_loader
// Parses decoded packet bytes from the UART/COBS receive path and turns them
// into frame-buffer writes. WRITE packets carry a start address followed by
// pixel pairs; FILL packets (build with FB_LOADER_FILL_CMD_EN defined) write
// one colour to a run of consecutive addresses. BUSY throttles the decoder
// while a write is outstanding.
//
// Configuration macro: FB_LOADER_FILL_CMD_EN
//   defined   : FILL command, FILL states and count register are built
//   undefined : CMD_FILL is an unknown opcode (ERR, packet discarded)
//
// Ports:
//   CLK       clock
//   RST       synchronous reset, active-low
//   IN_VALID  IN_DATA holds a payload byte (one-cycle strobe)
//   IN_DATA   payload byte
//   IN_END    packet boundary strobe (never together with IN_VALID)
//   BUSY      upstream must not strobe IN_VALID
//   WR_REQ    frame-buffer write request
//   WR_ADDR   write word address
//   WR_DATA   write pixel (RGB565)
//   WR_ACK    frame buffer accepts the write this cycle
//   ERR       one-cycle error pulse
//   PKT_DONE  one-cycle pulse on a cleanly closed packet
// -----------------------------------------------------------------------------
module fb_packet_loader #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] CMD_WRITE = fb_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_FILL  = fb_pkg::CMD_FILL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_END,
  output logic              BUSY,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [15:0]       WR_DATA,
  input  logic              WR_ACK,
  output logic              ERR,
  output logic              PKT_DONE
);

  import fb_pkg::*;

  state_e      r_state, w_state_next;
  logic [7:0]  r_byte_h, w_byte_h_next;   // shared high-byte latch for all fields
  logic        r_end_pending, w_end_pending_next;
  logic        r_err, w_err_next;
  logic        r_pkt_done, w_pkt_done_next;
`ifdef FB_LOADER_FILL_CMD_EN
  logic        r_is_fill, w_is_fill_next;
  logic [15:0] r_cnt, w_cnt_next;
`endif

  logic        w_busy;
  logic        w_close;
  logic        w_addr_load;
  logic        w_start;
  logic        w_hold;
  logic        w_wr_done;
  logic [15:0] w_word;

  assign w_busy = (r_state == ST_WAIT_ACK) || (r_state == ST_FILL_RUN);
  assign w_word = {r_byte_h, IN_DATA};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_byte_h      <= '0;
      r_end_pending <= 1'b0;
      r_err         <= 1'b0;
      r_pkt_done    <= 1'b0;
`ifdef FB_LOADER_FILL_CMD_EN
      r_is_fill     <= 1'b0;
      r_cnt         <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_byte_h      <= w_byte_h_next;
      r_end_pending <= w_end_pending_next;
      r_err         <= w_err_next;
      r_pkt_done    <= w_pkt_done_next;
`ifdef FB_LOADER_FILL_CMD_EN
      r_is_fill     <= w_is_fill_next;
      r_cnt         <= w_cnt_next;
`endif
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_next       = r_state;
    w_byte_h_next      = r_byte_h;
    w_end_pending_next = r_end_pending;
    w_err_next         = 1'b0;
    w_pkt_done_next    = 1'b0;
    w_close            = 1'b0;
    w_addr_load        = 1'b0;
    w_start            = 1'b0;
    w_hold             = 1'b0;
`ifdef FB_LOADER_FILL_CMD_EN
    w_is_fill_next     = r_is_fill;
    w_cnt_next         = r_cnt;
`endif

    if (w_busy) begin
      // Bytes arriving while busy are lost; boundaries are remembered once.
      w_err_next = IN_VALID;
      if (IN_END) w_end_pending_next = 1'b1;

      if (w_wr_done) begin
        if (r_state == ST_WAIT_ACK) begin
          w_close = r_end_pending | IN_END;
          if (!w_close) w_state_next = ST_PIX_H;
        end
`ifdef FB_LOADER_FILL_CMD_EN
        else begin
          w_cnt_next = r_cnt - 16'd1;
          w_close    = (r_cnt == 16'd1);
          w_hold     = (r_cnt != 16'd1);
        end
`endif
      end

      if (w_close) begin
        w_state_next       = ST_IDLE;
        w_end_pending_next = 1'b0;
        // A byte dropped in the closing cycle makes the packet unclean; the
        // ERR pulse wins so the two pulses never coincide.
        w_pkt_done_next    = !IN_VALID;
      end
    end else if (IN_VALID) begin
      case (r_state)
        ST_IDLE: begin
          if (IN_DATA == CMD_WRITE) begin
            w_state_next = ST_ADDR_H;
`ifdef FB_LOADER_FILL_CMD_EN
            w_is_fill_next = 1'b0;
          end else if (IN_DATA == CMD_FILL) begin
            w_state_next   = ST_ADDR_H;
            w_is_fill_next = 1'b1;
`else
          end else if (IN_DATA == CMD_FILL) begin
            // FILL not built: rejected exactly like an unknown opcode.
            w_err_next   = 1'b1;
            w_state_next = ST_DISCARD;
`endif
          end else begin
            w_err_next   = 1'b1;
            w_state_next = ST_DISCARD;
          end
        end
        ST_ADDR_H: begin
          w_byte_h_next = IN_DATA;
          w_state_next  = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          w_addr_load  = 1'b1;
`ifdef FB_LOADER_FILL_CMD_EN
          w_state_next = r_is_fill ? ST_CNT_H : ST_PIX_H;
`else
          w_state_next = ST_PIX_H;
`endif
        end
        ST_PIX_H: begin
          w_byte_h_next = IN_DATA;
          w_state_next  = ST_PIX_L;
        end
        ST_PIX_L: begin
          w_start      = 1'b1;
          w_state_next = ST_WAIT_ACK;
        end
`ifdef FB_LOADER_FILL_CMD_EN
        ST_CNT_H: begin
          w_byte_h_next = IN_DATA;
          w_state_next  = ST_CNT_L;
        end
        ST_CNT_L: begin
          w_cnt_next   = w_word;
          w_state_next = ST_COL_H;
        end
        ST_COL_H: begin
          w_byte_h_next = IN_DATA;
          w_state_next  = ST_COL_L;
        end
        ST_COL_L: begin
          if (r_cnt == 16'd0) begin
            w_pkt_done_next = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_start      = 1'b1;
            w_state_next = ST_FILL_RUN;
          end
        end
`endif
        default: ;  // DISCARD swallows payload bytes
      endcase
    end else if (IN_END) begin
      case (r_state)
        ST_IDLE: ;
        ST_PIX_H: begin
          w_pkt_done_next = 1'b1;
          w_state_next    = ST_IDLE;
        end
        ST_DISCARD: w_state_next = ST_IDLE;
        default: begin
          // Truncated header or half pixel: nothing is written for it.
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  fb_write_port #(
    .ADDR_W(ADDR_W)
  ) u_write_port (
    .CLK        (CLK),
    .RST        (RST),
    .i_addr_load(w_addr_load),
    .i_addr     (w_word[ADDR_W-1:0]),
    .i_start    (w_start),
    .i_data     (w_word),
    .i_hold     (w_hold),
    .i_ack      (WR_ACK),
    .o_req      (WR_REQ),
    .o_addr     (WR_ADDR),
    .o_data     (WR_DATA),
    .o_done     (w_wr_done)
  );

  assign BUSY     = w_busy;
  assign ERR      = r_err;
  assign PKT_DONE = r_pkt_done;

endmodule

// File: doc/fb_packet_loader.md
Name: fb_packet_loader

Overview:
- Sequencer between the UART/COBS receive path and the 16-bit frame buffer.
- Consumes decoded packet bytes and parses commands: WRITE (pixel run) and optionally FILL.
- Drives frame-buffer writes over a req/ack handshake.
- Throttles the decoder through BUSY so that no byte is lost while a write is outstanding.

Parameters:
- ADDR_W, 16, frame-buffer word-address width (1..16). Received 16-bit addresses are truncated to ADDR_W bits.
- CMD_WRITE, 8'h01, opcode of the pixel-run write command.
- CMD_FILL, 8'h02, opcode of the fill command (only used with FILL_CMD_EN).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- IN_VALID  in  1  one-cycle strobe: IN_DATA holds a decoded payload byte
- IN_DATA  in  8  decoded payload byte
- IN_END  in  1  one-cycle strobe: packet boundary (COBS 0x00 delimiter seen); never coincident with IN_VALID
- BUSY  out  1  high: upstream must not strobe IN_VALID
- WR_REQ  out  1  frame-buffer write request
- WR_ADDR  out  ADDR_W  write word address
- WR_DATA  out  16  write pixel (RGB565)
- WR_ACK  in  1  frame buffer accepts the write in this cycle
- ERR  out  1  one-cycle error pulse
- PKT_DONE  out  1  one-cycle pulse when a packet closes cleanly

Behaviour:
- Reset (RST=0 at a CLK edge) takes priority over everything and aborts any transaction:
  - state=IDLE
  - BUSY=0, WR_REQ=0, WR_ADDR=0, WR_DATA=0, ERR=0, PKT_DONE=0
  - end_pending=0; all internal registers 0
- Packet format:
  - WRITE: CMD, ADDR_H, ADDR_L, then {PIX_H, PIX_L} pairs until IN_END.
  - FILL: CMD, ADDR_H, ADDR_L, CNT_H, CNT_L, COL_H, COL_L.
- States and transitions:
  - IDLE: on IN_VALID, byte is the opcode. CMD_WRITE or CMD_FILL -> ADDR_H. Any other opcode -> DISCARD, with a one-cycle ERR pulse.
  - ADDR_H -> ADDR_L -> (WRITE: PIX_H; FILL: CNT_H).
  - PIX_H: latch the high byte -> PIX_L.
  - PIX_L: latch the low byte. On the next cycle WR_REQ=1 and BUSY=1, state=WAIT_ACK; latency is 1 cycle from the PIX_L strobe.
  - WAIT_ACK: WR_ADDR and WR_DATA stay stable while WR_REQ=1. On the cycle WR_ACK=1: WR_REQ falls next cycle, address increments modulo 2^ADDR_W (0xFFFF -> 0x0000 for ADDR_W=16), and the state returns to PIX_H.
  - CNT_H -> CNT_L -> COL_H -> COL_L. The COL_L byte triggers FILL_RUN.
  - FILL_RUN: BUSY=1. Performs cnt writes of the colour at consecutive addresses, one per WR_ACK. WR_REQ may stay high back-to-back, with address/count updating on each ack. Exits to IDLE with a PKT_DONE pulse when the remaining count reaches 0. cnt=0 performs no write and pulses PKT_DONE immediately.
  - DISCARD: ignore bytes until IN_END -> IDLE. No PKT_DONE.
- IN_END handling:
  - In PIX_H with at least one pixel written, or in PIX_H with zero pixels: PKT_DONE pulse, go to IDLE.
  - In WAIT_ACK or FILL_RUN: set end_pending. The boundary is handled once the operation completes.
  - In any header state, in PIX_L (half pixel), or in a FILL header state: ERR pulse, go to IDLE, nothing written for the partial item.
- IN_VALID while BUSY=1: byte dropped, ERR pulse, state unchanged.
- A second IN_END while end_pending=1 is ignored.
- ERR and PKT_DONE never assert in the same cycle.

Optional Feature:
- Macro FB_LOADER_FILL_CMD_EN.
- Defined: FILL command, FILL states and the count register are present.
- Undefined: CMD_FILL is treated as an unknown opcode (ERR pulse, DISCARD); FILL logic is not synthesised.

Decomposition:
- Shared package fb_pkg holds:
  - opcode constants CMD_WRITE and CMD_FILL
  - state enum for the loader
  - RGB565 pixel typedef (16 bits)
- The frame-buffer handshake is isolated as sub-module fb_write_port. It holds the WR_REQ/addr/data registers, performs the ack-driven address increment, and provides a "done" pulse.
- The parser FSM lives in fb_packet_loader.

Test Plan:
- Bytes 01,00,10,F8,00,07,E0 then IN_END, WR_ACK tied 1 -> writes (0x0010,0xF800) and (0x0011,0x07E0); one PKT_DONE; ERR never asserts.
- WRITE with WR_ACK delayed 5 cycles -> WR_REQ/WR_ADDR/WR_DATA held stable for 6 cycles; BUSY=1 for the whole window; an IN_VALID injected there -> ERR pulse and no extra write.
- Bytes 01,FF,FF,12,34,56,78 (ADDR_W=16) -> writes at 0xFFFF then 0x0000 (wrap).
- Bytes 01,00,00,AB then IN_END (half pixel) -> no write, ERR pulse, IDLE; a following valid packet is processed normally.
- Unknown opcode 7E,11,22 then IN_END -> ERR once, no writes, no PKT_DONE.
- FILL_CMD_EN defined: 02,00,20,00,03,00,1F -> writes 0x001F to 0x0020..0x0022, then PKT_DONE. Same bytes with the macro undefined -> ERR and no writes.
- Reset asserted during WAIT_ACK -> WR_REQ=0 on the next cycle; state IDLE.
